// File: rtl/stack_sequencer.sv
// Multi-byte stack push/pull engine for the 6502 core.
// Drives the SP register's din/we and issues byte-wide stack-page memory accesses.
module stack_sequencer #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-BIT_WIDTH-1:0] STACK_PAGE = 'h01
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [1:0]             cmd_len,
    input  logic [3*BIT_WIDTH-1:0] push_data,
    input  logic [BIT_WIDTH-1:0]   sp_in,
    output logic [BIT_WIDTH-1:0]   sp_din,
    output logic                   sp_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BIT_WIDTH-1:0]   mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [BIT_WIDTH-1:0]   mem_rdata,
    output logic [3*BIT_WIDTH-1:0] pull_data,
    output logic                   done
);

    typedef enum logic [2:0] {StIdle, StPush, StPullRd, StPullCap, StDone} state_e;

    localparam logic [BIT_WIDTH-1:0] One = 1;

    state_e                     state_q, state_d;
    logic [BIT_WIDTH-1:0]       sp_q, sp_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [1:0]                 len_q, len_d;
    logic [2:0][BIT_WIDTH-1:0]  data_q, data_d;
    logic [2:0][BIT_WIDTH-1:0]  pull_q, pull_d;
    logic [1:0]                 push_idx, pull_idx;
    logic [BIT_WIDTH-1:0]       sp_inc, sp_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sp_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            pull_q  <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            pull_q  <= pull_d;
        end
    end

    assign pull_data = pull_q;

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        data_d    = data_q;
        pull_d    = pull_q;
        cmd_ready = 1'b0;
        sp_din    = '0;
        sp_we     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        done      = 1'b0;
        // Pushes go MSB first; pulls fill from byte 0 upward.
        push_idx  = cnt_q - 2'd1;
        pull_idx  = len_q - cnt_q;
        sp_inc    = sp_q + One;
        sp_dec    = sp_q - One;

        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted, even though the state is already idle.
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    sp_d   = sp_in;
                    cnt_d  = cmd_len;
                    len_d  = cmd_len;
                    data_d = push_data;
                    if (cmd_len == 2'd0) begin
                        state_d = StDone;
                    end else if (cmd_dir) begin
                        pull_d  = '0;
                        state_d = StPullRd;
                    end else begin
                        state_d = StPush;
                    end
                end
            end
            StPush: begin
                mem_addr  = {STACK_PAGE, sp_q};
                mem_wdata = data_q[push_idx];
                mem_we    = 1'b1;
                sp_din    = sp_dec;
                sp_we     = 1'b1;
                sp_d      = sp_dec;
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = StDone;
            end
            StPullRd: begin
                mem_addr = {STACK_PAGE, sp_inc};
                mem_re   = 1'b1;
                sp_din   = sp_inc;
                sp_we    = 1'b1;
                sp_d     = sp_inc;
                state_d  = StPullCap;
            end
            StPullCap: begin
                pull_d[pull_idx] = mem_rdata;
                cnt_d            = cnt_q - 2'd1;
                state_d          = (cnt_q == 2'd1) ? StDone : StPullRd;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed and randomized checks of stack_sequencer against a transaction-level stack model.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [1:0]  cmd_len;
    logic [23:0] push_data;
    logic [7:0]  sp_in;
    logic [7:0]  sp_din;
    logic        sp_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [23:0] pull_data;
    logic        done;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    bit [7:0]   mem [256];
    bit [7:0]   ref_mem [256];
    logic [7:0] sp_reg = 8'h00;

    stack_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .push_data (push_data),
        .sp_in     (sp_in),
        .sp_din    (sp_din),
        .sp_we     (sp_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .pull_data (pull_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Stack-page memory and SP register as the surrounding core would provide them.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (sp_we) sp_reg <= sp_din;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs(input bit allow_valid);
        cmd_valid = allow_valid ? 1'($urandom) : 1'b0;
        cmd_dir   = 1'($urandom);
        cmd_len   = 2'($urandom);
        push_data = 24'($urandom);
        sp_in     = 8'($urandom);
    endtask

    task automatic run_cmd(input logic dir, input logic [1:0] len, input logic [7:0] sp,
                           input logic [23:0] pd);
        int n;
        int guard;
        logic [7:0]  s;
        logic [23:0] exp_pull;
        n = int'(len);
        s = sp;
        exp_pull = '0;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = len;
        sp_in     = sp;
        push_data = pd;
        @(negedge clk);
        if (n != 0 && !dir) begin
            for (int k = 0; k < n; k++) begin
                chk("push_we", {31'b0, mem_we}, 32'd1);
                chk("push_re", {31'b0, mem_re}, 32'd0);
                chk("push_addr", {16'b0, mem_addr}, {16'b0, 8'h01, s});
                chk("push_wdata", {24'b0, mem_wdata}, {24'b0, pd[8*(n-1-k) +: 8]});
                chk("push_sp_we", {31'b0, sp_we}, 32'd1);
                chk("push_sp_din", {24'b0, sp_din}, {24'b0, 8'(s - 8'd1)});
                chk("push_busy", {30'b0, cmd_ready, done}, 32'd0);
                ref_mem[s] = pd[8*(n-1-k) +: 8];
                s = s - 8'd1;
                junk_inputs(1'b1);
                @(negedge clk);
            end
        end else if (n != 0) begin
            for (int k = 0; k < n; k++) begin
                s = s + 8'd1;
                chk("pull_re", {31'b0, mem_re}, 32'd1);
                chk("pull_we", {31'b0, mem_we}, 32'd0);
                chk("pull_addr", {16'b0, mem_addr}, {16'b0, 8'h01, s});
                chk("pull_sp_we", {31'b0, sp_we}, 32'd1);
                chk("pull_sp_din", {24'b0, sp_din}, {24'b0, s});
                chk("pull_busy", {30'b0, cmd_ready, done}, 32'd0);
                exp_pull[8*k +: 8] = ref_mem[s];
                junk_inputs(1'b1);
                @(negedge clk);
                chk("cap_strobes", {29'b0, mem_we, mem_re, sp_we}, 32'd0);
                chk("cap_busy", {30'b0, cmd_ready, done}, 32'd0);
                junk_inputs(1'b1);
                @(negedge clk);
            end
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_strobes", {29'b0, mem_we, mem_re, sp_we}, 32'd0);
        chk("done_not_ready", {31'b0, cmd_ready}, 32'd0);
        if (dir && n != 0) chk("pull_data", {8'b0, pull_data}, {8'b0, exp_pull});
        junk_inputs(1'b0);
        @(negedge clk);
        chk("done_once", {31'b0, done}, 32'd0);
        chk("ready_after", {31'b0, cmd_ready}, 32'd1);
        if (n != 0) chk("sp_final", {24'b0, sp_reg}, {24'b0, s});
    endtask

    initial begin
        int we0;
        int done0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = 2'd0;
        push_data = '0;
        sp_in     = '0;

        @(negedge clk);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_strobes", {28'b0, mem_we, mem_re, sp_we, done}, 32'd0);
        chk("rst_pull_data", {8'b0, pull_data}, 32'd0);
        chk("rst_outs", {sp_din, mem_wdata, mem_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'b0, cmd_ready}, 32'd1);

        // JSR, then RTS returning the same address.
        run_cmd(1'b0, 2'd2, 8'hFD, 24'h00C012);
        chk("jsr_mem_fd", {24'b0, mem[8'hFD]}, 32'h0000_00C0);
        chk("jsr_mem_fc", {24'b0, mem[8'hFC]}, 32'h0000_0012);
        run_cmd(1'b1, 2'd2, 8'hFB, 24'h0);
        chk("rts_pull_data", {8'b0, pull_data}, 32'h0000_C012);

        // BRK across the bottom of the page.
        run_cmd(1'b0, 2'd3, 8'h01, 24'hAABBCC);
        chk("brk_sp", {24'b0, sp_reg}, 32'h0000_00FE);
        chk("brk_mem", {8'b0, mem[8'h01], mem[8'h00], mem[8'hFF]}, 32'h00AA_BBCC);

        // PLA at 0xFF wraps to 0x0100.
        run_cmd(1'b1, 2'd1, 8'hFF, 24'h0);
        chk("pla_wrap_data", {8'b0, pull_data}, 32'h0000_00BB);
        chk("pla_wrap_sp", {24'b0, sp_reg}, 32'h0);

        // No-op: done at cycle 1 without any strobe.
        we0 = we_cnt;
        run_cmd(1'b0, 2'd0, 8'h40, 24'h123456);
        chk("noop_no_write", we_cnt - we0, 32'd0);
        chk("noop_pull_data_kept", {8'b0, pull_data}, 32'h0000_00BB);

        // Reset after the first byte of a 3-byte push.
        we0 = we_cnt;
        done0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_len   = 2'd3;
        sp_in     = 8'h80;
        push_data = 24'h112233;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_first_we", {31'b0, mem_we}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_strobes", {28'b0, mem_we, mem_re, sp_we, done}, 32'd0);
        chk("abort_ready", {31'b0, cmd_ready}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        chk("abort_we_count", we_cnt - we0, 32'd1);
        chk("abort_no_done", done_cnt - done0, 32'd0);
        ref_mem[8'h80] = 8'h11;
        run_cmd(1'b1, 2'd1, 8'h7F, 24'h0);
        chk("abort_byte_kept", {8'b0, pull_data}, 32'h0000_0011);

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            run_cmd(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
